// File: rtl/cv32e40p_multi_breakage_monitor.sv
// Multi-channel leaky-bucket breakage monitor: per-replica error counters with sticky
// broken flags, early warnings, software repair and an aggregate health state.

module cv32e40p_mbm_channel #(
    parameter int COUNT_BIT          = 8,
    parameter int INC_DEC_BIT        = 2,
    parameter int INCREMENT          = 2,
    parameter int DECREMENT          = 1,
    parameter int WARN_THRESHOLD     = 50,
    parameter int BREAKING_THRESHOLD = 100
) (
    input  logic clk_gated,
    input  logic rst_n,
    input  logic err,
    input  logic set_broken,
    input  logic clear,
    output logic broken,
    output logic warn,
    output logic broken_nxt
);
    localparam logic [INC_DEC_BIT-1:0] INC_C  = INC_DEC_BIT'(INCREMENT);
    localparam logic [INC_DEC_BIT-1:0] DEC_C  = INC_DEC_BIT'(DECREMENT);
    localparam logic [COUNT_BIT:0]     CMAX   = {1'b0, {COUNT_BIT{1'b1}}};
    localparam logic [COUNT_BIT-1:0]   BTH    = COUNT_BIT'(BREAKING_THRESHOLD);
    localparam logic [COUNT_BIT-1:0]   WTH    = COUNT_BIT'(WARN_THRESHOLD);

    logic [COUNT_BIT-1:0] count, count_nxt, step, inc_val, dec_val;
    logic [COUNT_BIT:0]   sum;
    logic                 warn_nxt;

    // Extra MSB on the sum catches overflow so the counter clamps instead of wrapping.
    assign sum     = {1'b0, count} + (COUNT_BIT+1)'(INC_C);
    assign inc_val = (sum > CMAX) ? {COUNT_BIT{1'b1}} : sum[COUNT_BIT-1:0];
    assign dec_val = (count > COUNT_BIT'(DEC_C)) ? count - COUNT_BIT'(DEC_C) : '0;
    assign step    = err ? inc_val : dec_val;

    always_comb begin
        count_nxt  = count;
        broken_nxt = broken;
        warn_nxt   = warn;
        if (set_broken) begin
            broken_nxt = 1'b1;
        end else if (clear) begin
            count_nxt  = '0;
            broken_nxt = 1'b0;
            warn_nxt   = 1'b0;
        end else if (!broken) begin
            count_nxt  = step;
            broken_nxt = (step > BTH);
            warn_nxt   = (step > WTH);
        end
    end

    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            broken <= 1'b0;
            warn   <= 1'b0;
        end else begin
            count  <= count_nxt;
            broken <= broken_nxt;
            warn   <= warn_nxt;
        end
    end
endmodule

module cv32e40p_multi_breakage_monitor #(
    parameter int N_CH               = 3,
    parameter int COUNT_BIT          = 8,
    parameter int INC_DEC_BIT        = 2,
    parameter int INCREMENT          = 2,
    parameter int DECREMENT          = 1,
    parameter int WARN_THRESHOLD     = 50,
    parameter int BREAKING_THRESHOLD = 100,
    parameter int MIN_ALIVE          = 2,
    parameter int NB_W               = $clog2(N_CH+1),
    parameter int IDX_W              = $clog2(N_CH) | 1
) (
    input  logic              clk_gated,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   err_detected_i,
    input  logic [N_CH-1:0]   set_broken_i,
    input  logic [N_CH-1:0]   clear_i,
    output logic [N_CH-1:0]   is_broken_o,
    output logic [N_CH-1:0]   warn_o,
    output logic [NB_W-1:0]   n_broken_o,
    output logic [IDX_W-1:0]  first_broken_idx_o,
    output logic              first_broken_vld_o,
    output logic [1:0]        sys_state_o
);
    localparam logic [1:0] ST_NOMINAL  = 2'b00;
    localparam logic [1:0] ST_DEGRADED = 2'b01;
    localparam logic [1:0] ST_FAILED   = 2'b10;

    logic [N_CH-1:0]  broken_nxt;
    logic [IDX_W-1:0] first_nxt;
    logic [NB_W-1:0]  n_broken;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        cv32e40p_mbm_channel #(
            .COUNT_BIT          (COUNT_BIT),
            .INC_DEC_BIT        (INC_DEC_BIT),
            .INCREMENT          (INCREMENT),
            .DECREMENT          (DECREMENT),
            .WARN_THRESHOLD     (WARN_THRESHOLD),
            .BREAKING_THRESHOLD (BREAKING_THRESHOLD)
        ) u_ch (
            .clk_gated  (clk_gated),
            .rst_n      (rst_n),
            .err        (err_detected_i[g]),
            .set_broken (set_broken_i[g]),
            .clear      (clear_i[g]),
            .broken     (is_broken_o[g]),
            .warn       (warn_o[g]),
            .broken_nxt (broken_nxt[g])
        );
    end

    always_comb begin
        n_broken = '0;
        for (int i = 0; i < N_CH; i++) n_broken = n_broken + NB_W'(is_broken_o[i]);
    end
    assign n_broken_o = n_broken;

    always_comb begin
        if (n_broken == '0)                     sys_state_o = ST_NOMINAL;
        else if ((N_CH - int'(n_broken)) < MIN_ALIVE) sys_state_o = ST_FAILED;
        else                                    sys_state_o = ST_DEGRADED;
    end

    // Descending scan so the lowest simultaneously-breaking index wins.
    always_comb begin
        first_nxt = '0;
        for (int i = N_CH-1; i >= 0; i--) if (broken_nxt[i]) first_nxt = IDX_W'(i);
    end

    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            first_broken_vld_o <= 1'b0;
            first_broken_idx_o <= '0;
        end else if (broken_nxt == '0) begin
            first_broken_vld_o <= 1'b0;
            first_broken_idx_o <= '0;
        end else if (!first_broken_vld_o) begin
            first_broken_vld_o <= 1'b1;
            first_broken_idx_o <= first_nxt;
        end
    end
endmodule
